// File: rtl/dac_serializer.sv
// Serializes X/Y sin-cos samples as two 24-bit SPI (mode 0) DAC frames per transaction.
// Define DAC_SERIALIZER_OVR_CNT_EN to build the pending-overwrite counter on ovr_cnt.
module dac_serializer #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [3:0]  CMD     = 4'b0011
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [16:0] x_in,
  input  logic signed [16:0] y_in,
  input  logic               sample_valid,
  output logic               sclk,
  output logic               mosi,
  output logic               cs_n,
  output logic               busy,
  output logic [7:0]         ovr_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [8:0] LP_HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] LP_GAP_LAST  = 9'(2 * CLK_DIV - 1);

  function automatic logic [15:0] f_offset(input logic signed [16:0] s);
    if (s[16] != s[15]) return s[16] ? 16'h0000 : 16'hFFFF;
    return {~s[15], s[14:0]};
  endfunction

  function automatic logic [23:0] f_frame(input logic ch, input logic [15:0] code);
    return {CMD, 3'b000, ch, code};
  endfunction

  state_t      r_state;
  logic [8:0]  r_cnt;
  logic [4:0]  r_bit;
  logic        r_hi;
  logic        r_ch;
  logic [23:0] r_shift;
  logic [15:0] r_act_x, r_act_y;
  logic [15:0] r_pend_x, r_pend_y;
  logic        r_pend_full;
  logic        r_sclk, r_mosi, r_cs_n, r_busy;

  logic [15:0] w_x_code, w_y_code;
  logic [15:0] w_nx_x, w_nx_y;
  logic        w_half_end;
  logic        w_last_ygap;

  assign w_x_code    = f_offset(x_in);
  assign w_y_code    = f_offset(y_in);
  assign w_half_end  = (r_cnt == LP_HALF_LAST);
  assign w_last_ygap = (r_state == GAP) && r_ch && (r_cnt == LP_GAP_LAST);
  // At the end of a Y gap a pending pair takes priority over a same-cycle strobe.
  assign w_nx_x      = r_pend_full ? r_pend_x : w_x_code;
  assign w_nx_y      = r_pend_full ? r_pend_y : w_y_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_hi        <= 1'b0;
      r_ch        <= 1'b0;
      r_shift     <= '0;
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_full <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sample_valid) begin
            r_act_x <= w_x_code;
            r_act_y <= w_y_code;
            r_ch    <= 1'b0;
            r_shift <= f_frame(1'b0, w_x_code);
            r_mosi  <= CMD[3];
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_hi    <= 1'b1;
            r_sclk  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        SHIFT: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (r_hi) begin
              r_hi   <= 1'b0;
              r_sclk <= 1'b0;
              if (r_bit != 5'd23) begin
                r_shift <= {r_shift[22:0], 1'b0};
                r_mosi  <= r_shift[22];
              end
            end else if (r_bit == 5'd23) begin
              r_cs_n  <= 1'b1;
              r_mosi  <= 1'b0;
              r_state <= GAP;
            end else begin
              r_bit  <= r_bit + 5'd1;
              r_hi   <= 1'b1;
              r_sclk <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        GAP: begin
          if (r_cnt == LP_GAP_LAST) begin
            r_cnt <= '0;
            if (!r_ch) begin
              r_ch    <= 1'b1;
              r_shift <= f_frame(1'b1, r_act_y);
              r_mosi  <= CMD[3];
              r_cs_n  <= 1'b0;
              r_state <= SETUP;
            end else if (r_pend_full || sample_valid) begin
              r_act_x <= w_nx_x;
              r_act_y <= w_nx_y;
              r_ch    <= 1'b0;
              r_shift <= f_frame(1'b0, w_nx_x);
              r_mosi  <= CMD[3];
              r_cs_n  <= 1'b0;
              r_state <= SETUP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if ((r_state != IDLE) && sample_valid && !w_last_ygap) begin
        r_pend_x    <= w_x_code;
        r_pend_y    <= w_y_code;
        r_pend_full <= 1'b1;
      end else if (w_last_ygap && r_pend_full) begin
        r_pend_full <= sample_valid;
        if (sample_valid) begin
          r_pend_x <= w_x_code;
          r_pend_y <= w_y_code;
        end
      end
    end
  end

  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign cs_n = r_cs_n;
  assign busy = r_busy;

`ifdef DAC_SERIALIZER_OVR_CNT_EN
  logic [7:0] r_ovr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovr_cnt <= '0;
    end else if ((r_state != IDLE) && sample_valid && !w_last_ygap && r_pend_full
                 && (r_ovr_cnt != '1)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  assign ovr_cnt = r_ovr_cnt;
`else
  assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: two instances (CLK_DIV 2 and 1) checked every cycle against a
// timeline model, plus directed frame/latency checks with literal expectations.
module tb_dac_serializer;

  typedef struct packed {
    logic cs_n;
    logic sclk;
    logic mosi;
    logic mchk;
    logic busy;
  } exp_t;

  typedef struct {
    logic [23:0] w;
    int          nb;
    int          lowc;
  } rx_t;

  localparam exp_t IDLE_O = '{cs_n: 1'b1, sclk: 1'b0, mosi: 1'b0, mchk: 1'b0, busy: 1'b0};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [16:0] xs  = '0;
  logic signed [16:0] ys  = '0;
  logic [1:0]         sv  = '0;
  logic [1:0]         sclk_w, mosi_w, cs_w, busy_w;
  logic [7:0]         ovr_w [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dac_serializer #(.CLK_DIV(2), .CMD(4'b0011)) u_dut0 (
    .clk(clk), .rst(rst), .x_in(xs), .y_in(ys), .sample_valid(sv[0]),
    .sclk(sclk_w[0]), .mosi(mosi_w[0]), .cs_n(cs_w[0]), .busy(busy_w[0]), .ovr_cnt(ovr_w[0])
  );

  dac_serializer #(.CLK_DIV(1), .CMD(4'b0011)) u_dut1 (
    .clk(clk), .rst(rst), .x_in(xs), .y_in(ys), .sample_valid(sv[1]),
    .sclk(sclk_w[1]), .mosi(mosi_w[1]), .cs_n(cs_w[1]), .busy(busy_w[1]), .ovr_cnt(ovr_w[1])
  );

  // ---------------- timeline model ----------------
  exp_t        cur [2];
  exp_t        fut [2][$];
  logic        pend_v [2];
  logic [15:0] pend_x [2];
  logic [15:0] pend_y [2];
  int          ovr_m [2];

  function automatic logic [15:0] code_of(input logic signed [16:0] s);
    int v;
    v = int'(s);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v + 32768);
  endfunction

  task automatic push_txn(input int i, input logic [15:0] cx, input logic [15:0] cy);
    int d;
    logic [23:0] fr;
    d = (i == 0) ? 2 : 1;
    for (int ch = 0; ch < 2; ch++) begin
      fr = {4'b0011, 4'(ch), (ch == 0) ? cx : cy};
      for (int c = 0; c < d; c++) fut[i].push_back('{1'b0, 1'b0, fr[23], 1'b1, 1'b1});
      for (int k = 0; k < 24; k++) begin
        for (int c = 0; c < d; c++) fut[i].push_back('{1'b0, 1'b1, fr[23-k], 1'b1, 1'b1});
        for (int c = 0; c < d; c++)
          fut[i].push_back('{1'b0, 1'b0, (k < 23) ? fr[22-k] : 1'b0, (k < 23), 1'b1});
      end
      for (int c = 0; c < 2 * d; c++) fut[i].push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic step(input int i);
    logic [15:0] nx, ny;
    nx = code_of(xs);
    ny = code_of(ys);
    if (!cur[i].busy) begin
      if (sv[i]) push_txn(i, nx, ny);
    end else if (fut[i].size() == 0) begin
      if (pend_v[i]) begin
        push_txn(i, pend_x[i], pend_y[i]);
        pend_v[i] = sv[i];
        if (sv[i]) begin
          pend_x[i] = nx;
          pend_y[i] = ny;
        end
      end else if (sv[i]) begin
        push_txn(i, nx, ny);
      end
    end else if (sv[i]) begin
      if (pend_v[i] && ovr_m[i] < 255) ovr_m[i]++;
      pend_v[i] = 1'b1;
      pend_x[i] = nx;
      pend_y[i] = ny;
    end
    cur[i] = (fut[i].size() > 0) ? fut[i].pop_front() : IDLE_O;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fut[i].delete();
        cur[i]    = IDLE_O;
        pend_v[i] = 1'b0;
        ovr_m[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) step(i);
    end
  end

  // ---------------- SPI receiver ----------------
  rx_t         rxq [2][$];
  logic [23:0] rx_sh [2];
  int          rx_nb [2];
  int          rx_lowc [2];
  logic [1:0]  rx_ps = 2'b00;
  logic [1:0]  rx_pc = 2'b11;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_w[i] === 1'b0) begin
        rx_lowc[i]++;
        if (sclk_w[i] && !rx_ps[i]) begin
          rx_sh[i] = {rx_sh[i][22:0], mosi_w[i]};
          rx_nb[i]++;
        end
      end else if (rx_pc[i] === 1'b0) begin
        rxq[i].push_back('{rx_sh[i], rx_nb[i], rx_lowc[i]});
        rx_nb[i]   = 0;
        rx_lowc[i] = 0;
      end
      rx_ps[i] = sclk_w[i];
      rx_pc[i] = cs_w[i];
    end
  end

  // ---------------- comparison process ----------------
  string       cq_name [$];
  logic [39:0] cq_act [$];
  logic [39:0] cq_exp [$];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    cq_name.push_back(nm);
    cq_act.push_back(act);
    cq_exp.push_back(exp);
  endtask

  always @(negedge clk) begin : cmp
    string       nm;
    logic [39:0] a, e;
    logic [7:0]  eo;
    for (int i = 0; i < 2; i++) begin
`ifdef DAC_SERIALIZER_OVR_CNT_EN
      eo = 8'(ovr_m[i]);
`else
      eo = 8'd0;
`endif
      n_tests++;
      if (cs_w[i] !== cur[i].cs_n || sclk_w[i] !== cur[i].sclk || busy_w[i] !== cur[i].busy ||
          (cur[i].mchk && mosi_w[i] !== cur[i].mosi) || ovr_w[i] !== eo) begin
        n_fail++;
        $display("FAIL cycle dut%0d t=%0t cs_n,sclk,mosi,busy,ovr got %b%b%b%b %0d want %b%b%b%b %0d (mosi checked=%b)",
                 i, $time, cs_w[i], sclk_w[i], mosi_w[i], busy_w[i], ovr_w[i],
                 cur[i].cs_n, cur[i].sclk, cur[i].mosi, cur[i].busy, eo, cur[i].mchk);
      end
    end
    while (cq_name.size() > 0) begin
      nm = cq_name.pop_front();
      a  = cq_act.pop_front();
      e  = cq_exp.pop_front();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s got %h want %h", nm, a, e);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic strobe(input int i, input int x, input int y);
    xs    = 17'(x);
    ys    = 17'(y);
    sv[i] = 1'b1;
    @(negedge clk);
    sv[i] = 1'b0;
  endtask

  task automatic run_busy(input int i, input int max, output int n);
    n = 0;
    while (busy_w[i] && n < max) begin
      n++;
      xs = 17'($urandom);
      ys = 17'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic chk_frame(input int i, input string nm, input logic [23:0] w);
    rx_t r;
    logic [7:0] low_exp;
    low_exp = (i == 0) ? 8'd98 : 8'd49;
    if (rxq[i].size() == 0) begin
      chk(nm, 40'd0, {low_exp, 8'd24, w});
    end else begin
      r = rxq[i].pop_front();
      chk(nm, {8'(r.lowc), 8'(r.nb), r.w}, {low_exp, 8'd24, w});
    end
  endtask

  task automatic flush_rx();
    rxq[0].delete();
    rxq[1].delete();
  endtask

  initial begin
    int n;
    int k;
    int guard;
    logic p;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cs_n", 40'(cs_w[0]), 40'd1);
    chk("rst_sclk", 40'(sclk_w[0]), 40'd0);
    chk("rst_mosi", 40'(mosi_w[0]), 40'd0);
    chk("rst_busy", 40'(busy_w[0]), 40'd0);
    chk("rst_ovr", 40'(ovr_w[0]), 40'd0);
    chk("rst_cs_n_d1", 40'(cs_w[1]), 40'd1);
    flush_rx();
    repeat (4) @(negedge clk);
    chk("idle_busy", 40'(busy_w[0]), 40'd0);

    // zero and full-scale codes
    strobe(0, 0, 32767);
    run_busy(0, 300, n);
    chk("t2_busy_len", 40'(n), 40'd204);
    chk_frame(0, "t2_x_frame", 24'h308000);
    chk_frame(0, "t2_y_frame", 24'h31FFFF);
    chk("t2_no_extra", 40'(rxq[0].size()), 40'd0);
    repeat (3) @(negedge clk);

    // saturation at both ends
    strobe(0, 40000, -65536);
    run_busy(0, 300, n);
    chk("t3_busy_len", 40'(n), 40'd204);
    chk_frame(0, "t3_x_sat", 24'h30FFFF);
    chk_frame(0, "t3_y_sat", 24'h310000);
    repeat (3) @(negedge clk);

    // overwrite of pending, back-to-back transactions
    strobe(0, 100, -1);
    strobe(0, 5, 6);
    repeat (50) @(negedge clk);
    strobe(0, -32768, 1000);
    run_busy(0, 600, n);
    chk("t4_busy_len", 40'(n), 40'd356);
    chk_frame(0, "t4_a_x", 24'h308064);
    chk_frame(0, "t4_a_y", 24'h317FFF);
    chk_frame(0, "t4_c_x", 24'h300000);
    chk_frame(0, "t4_c_y", 24'h3183E8);
`ifdef DAC_SERIALIZER_OVR_CNT_EN
    chk("t4_ovr", 40'(ovr_w[0]), 40'd1);
`else
    chk("t4_ovr", 40'(ovr_w[0]), 40'd0);
`endif
    repeat (3) @(negedge clk);

    // reset in the middle of the X frame with a pending pair stored
    strobe(0, 1234, -1234);
    strobe(0, 7, 7);
    k = 0;
    guard = 0;
    p = sclk_w[0];
    while (k < 10 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (sclk_w[0] && !p) k++;
      p = sclk_w[0];
    end
    chk("t5_sclk_pulse10", 40'(k), 40'd10);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_cs_n", 40'(cs_w[0]), 40'd1);
    chk("t5_rst_sclk", 40'(sclk_w[0]), 40'd0);
    chk("t5_rst_busy", 40'(busy_w[0]), 40'd0);
    chk("t5_rst_mosi", 40'(mosi_w[0]), 40'd0);
    chk("t5_rst_ovr", 40'(ovr_w[0]), 40'd0);
    @(negedge clk);
    rst = 1'b0;
    flush_rx();
    repeat (3) @(negedge clk);
    chk("t5_no_pending_start", 40'(busy_w[0]), 40'd0);
    strobe(0, 1234, -1234);
    run_busy(0, 300, n);
    chk("t5_busy_len", 40'(n), 40'd204);
    chk_frame(0, "t5_x_frame", 24'h3084D2);
    chk_frame(0, "t5_y_frame", 24'h317B2E);
    repeat (3) @(negedge clk);

    // strobe on the last Y-gap cycle with pending empty
    strobe(0, -2, 2);
    repeat (203) @(negedge clk);
    chk("t6_last_gap_busy", 40'(busy_w[0]), 40'd1);
    chk("t6_last_gap_cs_n", 40'(cs_w[0]), 40'd1);
    strobe(0, -32767, 20000);
    chk("t6_cs_fall", 40'(cs_w[0]), 40'd0);
    chk("t6_still_busy", 40'(busy_w[0]), 40'd1);
    run_busy(0, 300, n);
    chk("t6_busy_len", 40'(n), 40'd204);
    chk_frame(0, "t6_p_x", 24'h307FFE);
    chk_frame(0, "t6_p_y", 24'h318002);
    chk_frame(0, "t6_q_x", 24'h300001);
    chk_frame(0, "t6_q_y", 24'h31CE20);
    repeat (3) @(negedge clk);

    // CLK_DIV=1, alternating full-scale codes
    strobe(1, 32767, -32768);
    strobe(1, -32768, 32767);
    run_busy(1, 400, n);
    chk("t7_busy_len", 40'(n), 40'd203);
    chk_frame(1, "t7_a_x", 24'h30FFFF);
    chk_frame(1, "t7_a_y", 24'h310000);
    chk_frame(1, "t7_b_x", 24'h300000);
    chk_frame(1, "t7_b_y", 24'h31FFFF);

    repeat (4) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_serializer.md
DAC_SERIALIZER -- requirements
Module: dac_serializer

Interface
REQ-001 Parameter CLK_DIV, default 2, SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CMD, default 4'b0011, 4-bit DAC command field (write-and-update) sent in every frame.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 x_in  input  17  signed cosine sample from the sin/cos generator.
REQ-006 y_in  input  17  signed sine sample from the sin/cos generator.
REQ-007 sample_valid  input  1  one-cycle strobe; x_in/y_in are valid in the same cycle.
REQ-008 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-009 mosi  output  1  SPI data, MSB first.
REQ-010 cs_n  output  1  active-low frame select.
REQ-011 busy  output  1  high while a transaction or gap is in progress.
REQ-012 ovr_cnt  output  8  saturating count of overwritten pending samples.

Function
REQ-013 Code conversion: saturate each 17-bit sample to [-32768, 32767], invert the MSB to get 16-bit offset binary (0 -> 0x8000, 32767 -> 0xFFFF, -32768 -> 0x0000).
REQ-014 Frame format: 24 bits = CMD[3:0], addr[3:0] (0 = X, 1 = Y), code[15:0], MSB first.
REQ-015 Transaction: X frame, gap, Y frame, gap; both codes latched together at acceptance.
REQ-016 FSM states: IDLE, SETUP, SHIFT, GAP; a channel bit selects X or Y.
REQ-017 IDLE with sample_valid high: latch both samples into the active register; cs_n goes low and mosi = frame bit 23 on the next edge (SETUP).
REQ-018 SETUP lasts CLK_DIV cycles with sclk low; then SHIFT produces 24 pulses (CLK_DIV high, CLK_DIV low each).
REQ-019 mosi updates only at the start of each sclk low phase; it is stable across every rising edge.
REQ-020 After the 24th low phase, cs_n goes high; GAP holds cs_n high and sclk low for 2*CLK_DIV cycles.
REQ-021 cs_n low time is exactly 49*CLK_DIV cycles; a full transaction spans 102*CLK_DIV cycles from the first cs_n fall to the end of the Y gap.
REQ-022 busy is high from the cycle after acceptance through the last Y-gap cycle; it is low only in IDLE.
REQ-023 sample_valid while busy: store the pair in a one-deep pending register.
REQ-024 sample_valid while pending is full: overwrite pending with the new pair; ovr_cnt increments and saturates at 255.
REQ-025 End of the Y gap with pending full: move pending to active and start a new X frame next cycle without entering IDLE.
REQ-026 Last Y-gap cycle with sample_valid and pending empty: the new pair goes directly to active and the X frame follows next cycle.
REQ-027 Last Y-gap cycle with sample_valid and pending full: pending goes to active and the new pair goes to pending; ovr_cnt does not change.
REQ-028 While busy, changes on x_in/y_in without sample_valid have no effect on shifted data.

Reset
REQ-029 rst asserted, including mid-frame, forces the following immediately: state IDLE, cs_n = 1, sclk = 0, mosi = 0, busy = 0, pending cleared, ovr_cnt = 0.
REQ-030 After rst deassertion, outputs stay at their reset values until the first accepted sample_valid.

Configuration
REQ-031 Macro DAC_SERIALIZER_OVR_CNT_EN defined: ovr_cnt behaves per REQ-024/027.
REQ-032 Macro undefined: the counter logic is omitted and ovr_cnt is constant 0; all other behaviour is unchanged.

Verification
REQ-033 CLK_DIV=2, x_in=0, y_in=32767 strobed once -> frames 0x308000 then 0x31FFFF; cs_n low for 98 cycles each; busy low after 204 cycles.
REQ-034 x_in=40000, y_in=-65536 -> X code 0xFFFF and Y code 0x0000 (saturation).
REQ-035 Three strobes during one transaction -> second pair overwritten, third pair sent next with no IDLE cycle between; ovr_cnt=1 (0 without macro).
REQ-036 rst pulse at sclk pulse 10 of the X frame -> cs_n=1, sclk=0, busy=0 the same cycle; the next strobe produces a complete, correct frame.
REQ-037 Strobe on the last Y-gap cycle with pending empty -> cs_n falls on the next cycle with the new X code.
REQ-038 CLK_DIV=1 -> the 24-bit frame is sampled correctly on every rising sclk edge; 0xFFFF to 0x0000 alternating pattern is checked bit-exact.
